// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the Add/NAND ALU sharing controller: FSM states,
// predicate and opcode encodings, and the predicate evaluation helper.
package alu_ctrl_pkg;

    localparam int W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        COND_ALWAYS = 2'b00,
        COND_C      = 2'b01,
        COND_Z      = 2'b10,
        COND_RSVD   = 2'b11
    } cond_t;

    localparam logic OP_NAND = 1'b0;
    localparam logic OP_ADD  = 1'b1;

    // The reserved code behaves like "always" so decode never has to trap it.
    function automatic logic pred_true(input cond_t cond, input logic c, input logic z);
        logic result;
        case (cond)
            COND_C:  result = c;
            COND_Z:  result = z;
            default: result = 1'b1;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/alu_share_ctrl_if.sv
// Request/grant and response bundle between the two requesters, the
// response consumer and the ALU sharing controller.
interface alu_share_ctrl_if
    import alu_ctrl_pkg::*;
#(
    parameter int W = W_DEF
);

    logic         req0;
    logic         req1;
    logic         op0;
    logic         op1;
    logic [1:0]   cond0;
    logic [1:0]   cond1;
    logic         fwe0;
    logic         fwe1;
    logic [W-1:0] a0;
    logic [W-1:0] b0;
    logic [W-1:0] a1;
    logic [W-1:0] b1;
    logic         gnt0;
    logic         gnt1;

    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [W-1:0] rsp_result;
    logic         rsp_carry;
    logic         rsp_zero;
    logic         rsp_skipped;

    logic         c_flag;
    logic         z_flag;

    modport master (
        output req0, req1, op0, op1, cond0, cond1, fwe0, fwe1,
        output a0, b0, a1, b1,
        input  gnt0, gnt1,
        input  rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_zero, rsp_skipped,
        output rsp_ready,
        input  c_flag, z_flag
    );

    modport slave (
        input  req0, req1, op0, op1, cond0, cond1, fwe0, fwe1,
        input  a0, b0, a1, b1,
        output gnt0, gnt1,
        output rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_zero, rsp_skipped,
        input  rsp_ready,
        output c_flag, z_flag
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin picker; purely combinational, the caller owns the
// last-winner history bit.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // On contention the requester that did not win last time goes first.
    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
            gnt = last ? 2'b01 : 2'b10;
        end else if (req[0]) begin
            gnt = 2'b01;
        end else if (req[1]) begin
            gnt = 2'b10;
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one Add/NAND ALU between two requesters: round-robin grant, operand
// capture, predicated execution against the C/Z flags, valid/ready response.
module alu_share_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic           clk,
    input  logic           reset,
    alu_share_ctrl_if.slave bus
);

    state_t       state_q;
    state_t       state_d;
    logic         last_q;
    logic [1:0]   arb_req;
    logic [1:0]   arb_gnt;
    logic         grant_en;
    logic         load_rsp;

    logic         cap_op;
    cond_t        cap_cond;
    logic         cap_fwe;
    logic         cap_id;
    logic [W-1:0] cap_a;
    logic [W-1:0] cap_b;

    logic [W:0]   sum_wide;
    logic [W-1:0] alu_result;
    logic         alu_carry;
    logic         alu_zero;
    logic         exec_ok;

    logic         rsp_id_q;
    logic [W-1:0] rsp_result_q;
    logic         rsp_carry_q;
    logic         rsp_zero_q;
    logic         rsp_skipped_q;
    logic         c_q;
    logic         z_q;

    assign arb_req = {bus.req1, bus.req0};

    rr_arb2 u_arb (
        .req  (arb_req),
        .last (last_q),
        .gnt  (arb_gnt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Grants exist only in IDLE, so requests raised during EXEC/RESP simply wait.
    always_comb begin
        state_d  = state_q;
        grant_en = 1'b0;
        load_rsp = 1'b0;
        bus.gnt0 = 1'b0;
        bus.gnt1 = 1'b0;
        case (state_q)
            IDLE: begin
                if (|arb_req) begin
                    grant_en = 1'b1;
                    bus.gnt0 = arb_gnt[0];
                    bus.gnt1 = arb_gnt[1];
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                load_rsp = 1'b1;
                state_d  = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset history favours requester 0 on the first contested grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q   <= 1'b1;
            cap_op   <= OP_NAND;
            cap_cond <= COND_ALWAYS;
            cap_fwe  <= 1'b0;
            cap_id   <= 1'b0;
            cap_a    <= '0;
            cap_b    <= '0;
        end else if (grant_en) begin
            if (arb_gnt[1]) begin
                last_q   <= 1'b1;
                cap_id   <= 1'b1;
                cap_op   <= bus.op1;
                cap_cond <= cond_t'(bus.cond1);
                cap_fwe  <= bus.fwe1;
                cap_a    <= bus.a1;
                cap_b    <= bus.b1;
            end else begin
                last_q   <= 1'b0;
                cap_id   <= 1'b0;
                cap_op   <= bus.op0;
                cap_cond <= cond_t'(bus.cond0);
                cap_fwe  <= bus.fwe0;
                cap_a    <= bus.a0;
                cap_b    <= bus.b0;
            end
        end
    end

    always_comb begin
        sum_wide = {1'b0, cap_a} + {1'b0, cap_b};
        exec_ok  = pred_true(cap_cond, c_q, z_q);
        if (cap_op == OP_ADD) begin
            alu_result = sum_wide[W-1:0];
            alu_carry  = sum_wide[W];
        end else begin
            alu_result = ~(cap_a & cap_b);
            alu_carry  = 1'b0;
        end
        alu_zero = ~|alu_result;
    end

    // A skipped operation reports all-zero results and leaves the flags alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_id_q      <= 1'b0;
            rsp_result_q  <= '0;
            rsp_carry_q   <= 1'b0;
            rsp_zero_q    <= 1'b0;
            rsp_skipped_q <= 1'b0;
        end else if (load_rsp) begin
            rsp_id_q <= cap_id;
            if (exec_ok) begin
                rsp_result_q  <= alu_result;
                rsp_carry_q   <= alu_carry;
                rsp_zero_q    <= alu_zero;
                rsp_skipped_q <= 1'b0;
            end else begin
                rsp_result_q  <= '0;
                rsp_carry_q   <= 1'b0;
                rsp_zero_q    <= 1'b0;
                rsp_skipped_q <= 1'b1;
            end
        end
    end

    // NAND never disturbs carry, so a later ADC still sees the last add's carry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c_q <= 1'b0;
            z_q <= 1'b0;
        end else if (load_rsp && exec_ok && cap_fwe) begin
            z_q <= alu_zero;
            if (cap_op == OP_ADD) begin
                c_q <= alu_carry;
            end
        end
    end

    assign bus.rsp_valid   = (state_q == RESP);
    assign bus.rsp_id      = rsp_id_q;
    assign bus.rsp_result  = rsp_result_q;
    assign bus.rsp_carry   = rsp_carry_q;
    assign bus.rsp_zero    = rsp_zero_q;
    assign bus.rsp_skipped = rsp_skipped_q;
    assign bus.c_flag      = c_q;
    assign bus.z_flag      = z_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl: single operations, predicates, flag
// behaviour, round-robin contention, backpressure and mid-operation reset.
module tb_alu_share_ctrl;
    import alu_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    alu_share_ctrl_if #(.W(16)) bus ();

    alu_share_ctrl #(.W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic clear_requests();
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
    endtask

    task automatic apply_stimulus(input logic id, input logic op, input logic [1:0] cond, input logic fwe,
                                  input logic [15:0] a, input logic [15:0] b);
        if (id) begin
            bus.req1 = 1'b1; bus.op1 = op; bus.cond1 = cond; bus.fwe1 = fwe; bus.a1 = a; bus.b1 = b;
        end else begin
            bus.req0 = 1'b1; bus.op0 = op; bus.cond0 = cond; bus.fwe0 = fwe; bus.a0 = a; bus.b0 = b;
        end
    endtask

    task automatic check_rsp(input string tag, input logic id, input logic [15:0] exp_result,
                             input logic exp_carry, input logic exp_zero, input logic exp_skip,
                             input logic exp_c, input logic exp_z);
        check_output($sformatf("%s.rsp_valid", tag), 32'(bus.rsp_valid), 32'd1);
        check_output($sformatf("%s.rsp_id", tag), 32'(bus.rsp_id), 32'(id));
        check_output($sformatf("%s.rsp_result", tag), 32'(bus.rsp_result), 32'(exp_result));
        check_output($sformatf("%s.rsp_carry", tag), 32'(bus.rsp_carry), 32'(exp_carry));
        check_output($sformatf("%s.rsp_zero", tag), 32'(bus.rsp_zero), 32'(exp_zero));
        check_output($sformatf("%s.rsp_skipped", tag), 32'(bus.rsp_skipped), 32'(exp_skip));
        check_output($sformatf("%s.c_flag", tag), 32'(bus.c_flag), 32'(exp_c));
        check_output($sformatf("%s.z_flag", tag), 32'(bus.z_flag), 32'(exp_z));
    endtask

    // One uncontested operation: grant at N, EXEC at N+1, response at N+2, IDLE at N+3.
    task automatic run_op(input string tag, input logic id, input logic op, input logic [1:0] cond,
                          input logic fwe, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp_result, input logic exp_carry, input logic exp_zero,
                          input logic exp_skip, input logic exp_c, input logic exp_z);
        apply_stimulus(id, op, cond, fwe, a, b);
        #1;
        check_output($sformatf("%s.gnt0", tag), 32'(bus.gnt0), 32'(!id));
        check_output($sformatf("%s.gnt1", tag), 32'(bus.gnt1), 32'(id));
        tick();
        clear_requests();
        #1;
        check_output($sformatf("%s.exec_valid", tag), 32'(bus.rsp_valid), 32'd0);
        tick();
        check_rsp(tag, id, exp_result, exp_carry, exp_zero, exp_skip, exp_c, exp_z);
        tick();
        check_output($sformatf("%s.valid_drop", tag), 32'(bus.rsp_valid), 32'd0);
    endtask

    initial begin
        clear_requests();
        bus.op0 = 1'b0; bus.op1 = 1'b0; bus.cond0 = 2'b00; bus.cond1 = 2'b00;
        bus.fwe0 = 1'b0; bus.fwe1 = 1'b0;
        bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
        bus.rsp_ready = 1'b1;

        tick();
        tick();
        check_output("reset.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_output("reset.gnt0", 32'(bus.gnt0), 32'd0);
        check_output("reset.gnt1", 32'(bus.gnt1), 32'd0);
        check_output("reset.rsp_result", 32'(bus.rsp_result), 32'd0);
        check_output("reset.c_flag", 32'(bus.c_flag), 32'd0);
        check_output("reset.z_flag", 32'(bus.z_flag), 32'd0);
        reset = 1'b0;
        tick();

        run_op("add_7fff", 1'b0, OP_ADD, 2'b00, 1'b1, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("add_ovf", 1'b1, OP_ADD, 2'b00, 1'b1, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        run_op("adc_ifc", 1'b0, OP_ADD, 2'b01, 1'b1, 16'h0002, 16'h0003, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("skip_ifc", 1'b0, OP_ADD, 2'b01, 1'b1, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op("set_c", 1'b1, OP_ADD, 2'b00, 1'b1, 16'hFFFF, 16'h0002, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        run_op("nand_ff", 1'b0, OP_NAND, 2'b00, 1'b1, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        run_op("nand_ifz", 1'b1, OP_NAND, 2'b10, 1'b0, 16'h0F0F, 16'h00FF, 16'hFFF0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        run_op("add_rsvd", 1'b1, OP_ADD, 2'b11, 1'b1, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] contention with both requests held");
        apply_stimulus(1'b0, OP_ADD, 2'b00, 1'b0, 16'h0010, 16'h0001);
        apply_stimulus(1'b1, OP_NAND, 2'b00, 1'b0, 16'h00F0, 16'h0F00);
        #1;
        for (int k = 0; k < 4; k++) begin
            logic exp_id;
            exp_id = 1'((k % 2) == 1);
            check_output($sformatf("rr%0d.gnt0", k), 32'(bus.gnt0), 32'(!exp_id));
            check_output($sformatf("rr%0d.gnt1", k), 32'(bus.gnt1), 32'(exp_id));
            tick();
            check_output($sformatf("rr%0d.exec_gnt", k), 32'({bus.gnt1, bus.gnt0}), 32'd0);
            tick();
            check_rsp($sformatf("rr%0d", k), exp_id, exp_id ? 16'hFFFF : 16'h0011,
                      1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            check_output($sformatf("rr%0d.resp_gnt", k), 32'({bus.gnt1, bus.gnt0}), 32'd0);
            tick();
        end

        $display("[TB] backpressure with rsp_ready low");
        check_output("bp.gnt0", 32'(bus.gnt0), 32'd1);
        bus.rsp_ready = 1'b0;
        tick();
        tick();
        check_rsp("bp_first", 1'b0, 16'h0011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_output($sformatf("bp%0d.rsp_valid", i), 32'(bus.rsp_valid), 32'd1);
            check_output($sformatf("bp%0d.rsp_result", i), 32'(bus.rsp_result), 32'h0011);
            check_output($sformatf("bp%0d.rsp_id", i), 32'(bus.rsp_id), 32'd0);
            check_output($sformatf("bp%0d.gnt", i), 32'({bus.gnt1, bus.gnt0}), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        tick();
        check_output("bp_done.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_output("bp_done.gnt1", 32'(bus.gnt1), 32'd1);
        clear_requests();
        #1;
        check_output("bp_done.gnt_clear", 32'({bus.gnt1, bus.gnt0}), 32'd0);
        tick();

        $display("[TB] reset during EXEC");
        run_op("pre_rst", 1'b0, OP_ADD, 2'b00, 1'b1, 16'hFFFF, 16'h0002, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        apply_stimulus(1'b1, OP_ADD, 2'b00, 1'b1, 16'hFFFF, 16'h0001);
        #1;
        check_output("rst_op.gnt1", 32'(bus.gnt1), 32'd1);
        tick();
        clear_requests();
        reset = 1'b1;
        #1;
        check_output("rst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_output("rst.gnt", 32'({bus.gnt1, bus.gnt0}), 32'd0);
        check_output("rst.rsp_result", 32'(bus.rsp_result), 32'd0);
        check_output("rst.rsp_carry", 32'(bus.rsp_carry), 32'd0);
        check_output("rst.rsp_id", 32'(bus.rsp_id), 32'd0);
        check_output("rst.rsp_zero", 32'(bus.rsp_zero), 32'd0);
        check_output("rst.rsp_skipped", 32'(bus.rsp_skipped), 32'd0);
        check_output("rst.c_flag", 32'(bus.c_flag), 32'd0);
        check_output("rst.z_flag", 32'(bus.z_flag), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_output($sformatf("post_rst%0d.rsp_valid", i), 32'(bus.rsp_valid), 32'd0);
            check_output($sformatf("post_rst%0d.c_flag", i), 32'(bus.c_flag), 32'd0);
        end

        apply_stimulus(1'b0, OP_ADD, 2'b00, 1'b0, 16'h0001, 16'h0001);
        apply_stimulus(1'b1, OP_ADD, 2'b00, 1'b0, 16'h0002, 16'h0002);
        #1;
        check_output("post_rst_rr.gnt0", 32'(bus.gnt0), 32'd1);
        check_output("post_rst_rr.gnt1", 32'(bus.gnt1), 32'd0);
        clear_requests();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
